// File: rtl/cpu_pkg.sv
// Shared core definitions: instruction-fetch FSM states, error causes and the
// canonical NOP used to fill the instruction register.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } ifetch_state_t;

  localparam logic [1:0]  IF_CAUSE_NONE     = 2'b00;
  localparam logic [1:0]  IF_CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0]  IF_CAUSE_TIMEOUT  = 2'b10;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-stage bundle: core-side PC/instruction signals plus the
// instruction-memory request/acknowledge bus.
interface ifetch_unit_if;

  logic [31:0] PCaddr;
  logic        dbusy;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic        iready;
  logic        ifetch_err;
  logic [1:0]  ifetch_cause;

  modport master (
    input  PCaddr, dbusy, imem_ack, imem_rdata,
    output imem_req, imem_addr, instr, iready, ifetch_err, ifetch_cause
  );

  modport slave (
    output PCaddr, dbusy, imem_ack, imem_rdata,
    input  imem_req, imem_addr, instr, iready, ifetch_err, ifetch_cause
  );

endinterface

// File: rtl/ifetch_unit_wdog.sv
// Saturating count of REQ cycles spent waiting for an acknowledge; expired
// is raised once the count sits at MAX_WAIT-1.
module fetch_wdog #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic RST,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int            CW    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Counter register.
  always_ff @(posedge clk) begin
    if (RST) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Clear has priority; counting stops at the limit instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CW{1'b0}};
    end else if (en && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Limit decode.
  always_comb begin
    expired = (cnt_q == LIMIT);
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: samples PCaddr, runs one request/ack transaction on
// the instruction bus, latches the word and pulses iready for one cycle.
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic             clk,
  input  logic             RST,
  ifetch_unit_if.master    bus
);

  ifetch_state_t state_q, state_d;
  logic [31:0]   addr_q,  addr_d;
  logic [31:0]   instr_q, instr_d;
  logic [1:0]    cause_q, cause_d;

  logic          wdog_clear;
  logic          wdog_en;
  logic          wdog_expired;

  fetch_wdog #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wdog (
    .clk     (clk),
    .RST     (RST),
    .clear   (wdog_clear),
    .en      (wdog_en),
    .expired (wdog_expired)
  );

  // State and datapath registers; reset overrides every transition.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= 32'h0000_0000;
      instr_q <= NOP_INSTR;
      cause_q <= IF_CAUSE_NONE;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      cause_q <= cause_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: begin
        if (bus.dbusy) begin
          state_d = IDLE;
        end else if (bus.PCaddr[1:0] != 2'b00) begin
          state_d = ERR;
          cause_d = IF_CAUSE_MISALIGN;
        end else begin
          state_d = REQ;
          addr_d  = bus.PCaddr;
        end
      end
      REQ: begin
        // A late ack in the final wait cycle still wins over the timeout.
        if (bus.imem_ack) begin
          state_d = DONE;
          instr_d = bus.imem_rdata;
        end else if (wdog_expired) begin
          state_d = ERR;
          instr_d = NOP_INSTR;
          cause_d = IF_CAUSE_TIMEOUT;
        end else begin
          state_d = REQ;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state; the watchdog restarts outside REQ.
  always_comb begin
    bus.imem_req     = (state_q == REQ);
    bus.imem_addr    = addr_q;
    bus.instr        = instr_q;
    bus.iready       = (state_q == DONE);
    bus.ifetch_err   = (state_q == ERR);
    bus.ifetch_cause = cause_q;
    wdog_clear       = (state_q != REQ);
    wdog_en          = (state_q == REQ) && !bus.imem_ack;
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed and randomized fetch transactions checked against a
// transaction-level expectation of the fetch stage.
module tb_ifetch_unit;
  import cpu_pkg::NOP_INSTR;

  localparam int MAX_WAIT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ifetch_unit_if bus ();

  ifetch_unit #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .RST (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_instr;
  logic        exp_err;
  logic [1:0]  exp_cause;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_status(input string tag);
    chk({tag, ".instr"}, bus.instr, exp_instr);
    chk({tag, ".err"},   {31'd0, bus.ifetch_err}, {31'd0, exp_err});
    chk({tag, ".cause"}, {30'd0, bus.ifetch_cause}, {30'd0, exp_cause});
  endtask

  // Two reset cycles with a spurious ack, then park in IDLE with dbusy high.
  task automatic do_reset();
    rst            = 1'b1;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = $urandom;
    bus.dbusy      = 1'b0;
    bus.PCaddr     = 32'h0000_0000;
    tick();
    tick();
    exp_instr = NOP_INSTR;
    exp_err   = 1'b0;
    exp_cause = 2'b00;
    chk("rst.req",    {31'd0, bus.imem_req}, 32'd0);
    chk("rst.iready", {31'd0, bus.iready},   32'd0);
    chk("rst.addr",   bus.imem_addr,         32'd0);
    chk_status("rst");
    rst          = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dbusy    = 1'b1;
    tick();
    chk("rst.idle_req", {31'd0, bus.imem_req}, 32'd0);
  endtask

  // One fetch starting from an IDLE cycle: `busy` cycles of dbusy, then
  // `waits` cycles of no ack before the ack (timeout if waits >= MAX_WAIT).
  task automatic fetch(input logic [31:0] pc, input int waits, input logic [31:0] data,
                       input bit move_pc, input int busy);
    bit acked;
    for (int i = 0; i < busy; i++) begin
      bus.dbusy    = 1'b1;
      bus.PCaddr   = pc;
      bus.imem_ack = 1'($urandom_range(0, 1));
      tick();
      chk("yield.req", {31'd0, bus.imem_req}, 32'd0);
    end
    bus.dbusy      = 1'b0;
    bus.PCaddr     = pc;
    bus.imem_ack   = 1'($urandom_range(0, 1));
    bus.imem_rdata = $urandom;
    tick();
    acked = 1'b0;
    for (int k = 1; k <= MAX_WAIT && !acked; k++) begin
      chk("req.req",    {31'd0, bus.imem_req}, 32'd1);
      chk("req.addr",   bus.imem_addr,         pc);
      chk("req.iready", {31'd0, bus.iready},   32'd0);
      bus.dbusy = 1'($urandom_range(0, 1));
      if (move_pc) bus.PCaddr = 32'h0000_0200;
      acked          = (k == waits + 1);
      bus.imem_ack   = acked;
      bus.imem_rdata = acked ? data : $urandom;
      tick();
    end
    if (acked) begin
      exp_instr = data;
      chk("done.iready", {31'd0, bus.iready},   32'd1);
      chk("done.req",    {31'd0, bus.imem_req}, 32'd0);
      chk_status("done");
      bus.imem_ack   = 1'($urandom_range(0, 1));
      bus.imem_rdata = $urandom;
      tick();
      chk("idle.iready", {31'd0, bus.iready},   32'd0);
      chk("idle.req",    {31'd0, bus.imem_req}, 32'd0);
      chk_status("idle");
    end else begin
      exp_instr = NOP_INSTR;
      exp_err   = 1'b1;
      exp_cause = 2'b10;
      chk("tmo.req",    {31'd0, bus.imem_req}, 32'd0);
      chk("tmo.iready", {31'd0, bus.iready},   32'd0);
      chk_status("tmo");
    end
  endtask

  // Misaligned PC from IDLE; ERR must hold whatever the inputs do.
  task automatic misalign(input logic [31:0] pc);
    bus.dbusy    = 1'b0;
    bus.PCaddr   = pc;
    bus.imem_ack = 1'b0;
    tick();
    exp_err   = 1'b1;
    exp_cause = 2'b01;
    chk("mis.req", {31'd0, bus.imem_req}, 32'd0);
    chk_status("mis");
    for (int i = 0; i < 4; i++) begin
      bus.PCaddr   = $urandom & 32'hFFFF_FFFC;
      bus.dbusy    = 1'($urandom_range(0, 1));
      bus.imem_ack = 1'($urandom_range(0, 1));
      tick();
      chk("err.req",    {31'd0, bus.imem_req}, 32'd0);
      chk("err.iready", {31'd0, bus.iready},   32'd0);
      chk_status("err");
    end
  endtask

  initial begin
    bus.PCaddr     = 32'h0000_0000;
    bus.dbusy      = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0000_0000;
    do_reset();

    fetch(32'h0000_0100, 0, 32'h0050_0093, 1'b0, 0);
    fetch(32'h0000_0100, 5, 32'h0010_0113, 1'b1, 0);
    fetch(32'h0000_0104, 0, $urandom, 1'b0, 4);
    fetch(32'h0000_0108, MAX_WAIT, $urandom, 1'b0, 0);
    do_reset();
    fetch(32'h0000_010C, MAX_WAIT - 1, 32'h00A0_0513, 1'b0, 0);
    misalign(32'h0000_0102);
    do_reset();

    // Reset while a request is outstanding.
    bus.dbusy  = 1'b0;
    bus.PCaddr = 32'h0000_0300;
    tick();
    chk("rreq.req", {31'd0, bus.imem_req}, 32'd1);
    rst = 1'b1;
    tick();
    chk("rreq.drop", {31'd0, bus.imem_req}, 32'd0);
    do_reset();

    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        misalign(($urandom & 32'hFFFF_FFFC) | 32'(1 + $urandom_range(0, 2)));
      end else begin
        fetch($urandom & 32'hFFFF_FFFC,
              ($urandom_range(0, 7) == 0) ? int'($urandom_range(MAX_WAIT - 2, MAX_WAIT + 1))
                                          : int'($urandom_range(0, 6)),
              $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end
      if (exp_err) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
